// File: rtl/add_result_writeback.sv
// ============================================================================
// Module      : add_result_writeback
// Description : Buffers int8 ADD result vectors in a FWFT FIFO and writes them
//               to the output SRAM with tail strobes and an almost-full stall.
//               Optional stall-cycle counter: ADD_WB_PERF_CNT_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module add_result_writeback #(
  parameter int MAX_VECTOR_SIZE = 8,
  parameter int FIFO_DEPTH      = 4,
  parameter int STALL_MARGIN    = 2,
  parameter int ADDR_WIDTH      = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  input  logic [31:0]                  num_elements,
  input  logic [8*MAX_VECTOR_SIZE-1:0] data_i,
  input  logic                         valid_i,
  output logic                         stall_o,
  output logic                         mem_req_o,
  output logic [ADDR_WIDTH-1:0]        mem_addr_o,
  output logic [8*MAX_VECTOR_SIZE-1:0] mem_wdata_o,
  output logic [MAX_VECTOR_SIZE-1:0]   mem_wstrb_o,
  input  logic                         mem_ready_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         overflow_o,
  output logic [31:0]                  stall_cycles_o
);

  localparam int                 c_ptr_w  = $clog2(FIFO_DEPTH);
  localparam int                 c_cnt_w  = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth  = c_cnt_w'(FIFO_DEPTH);
  localparam logic [31:0]        c_lanes  = 32'(MAX_VECTOR_SIZE);
  localparam logic [31:0]        c_margin = 32'(STALL_MARGIN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [ADDR_WIDTH-1:0]        r_base;
  logic [31:0]                  r_total;
  logic [31:0]                  r_tail;
  logic [31:0]                  r_widx;
  logic [31:0]                  r_rcnt;
  logic [8*MAX_VECTOR_SIZE-1:0] r_fifo [FIFO_DEPTH];
  logic [c_ptr_w-1:0]           r_wr_ptr;
  logic [c_ptr_w-1:0]           r_rd_ptr;
  logic [c_cnt_w-1:0]           r_count;
  logic                         r_overflow;
  logic                         r_stall;

  logic                         w_busy;
  logic                         w_req;
  logic                         w_pop;
  logic                         w_push;
  logic                         w_drop;
  logic                         w_full;
  logic                         w_start_ok;
  logic                         w_last_vec;
  logic                         w_last_hs;
  logic [31:0]                  w_job_tail;
  logic [31:0]                  w_job_total;
  logic [c_cnt_w-1:0]           w_count_nxt;
  logic [c_cnt_w-1:0]           w_free_nxt;
  logic [MAX_VECTOR_SIZE-1:0]   w_strb;

  assign w_busy      = (r_state == ST_RUN);
  assign w_req       = w_busy && (r_count != '0);
  assign w_pop       = w_req && mem_ready_i;
  assign w_full      = (r_count == c_depth);
  assign w_start_ok  = (r_state == ST_IDLE) && start;
  // Only the first total_vec vectors of a job are accepted; anything else is lost.
  assign w_push      = valid_i && w_busy && (r_rcnt < r_total) && (!w_full || w_pop);
  assign w_drop      = valid_i && !w_push;
  assign w_count_nxt = r_count + {{c_ptr_w{1'b0}}, w_push} - {{c_ptr_w{1'b0}}, w_pop};
  assign w_free_nxt  = c_depth - w_count_nxt;
  assign w_job_tail  = num_elements % c_lanes;
  assign w_job_total = (num_elements / c_lanes) + {31'd0, (w_job_tail != 32'd0)};
  assign w_last_vec  = (r_widx + 32'd1) == r_total;
  assign w_last_hs   = w_pop && w_last_vec;

  generate
    for (genvar i = 0; i < MAX_VECTOR_SIZE; i++) begin : g_strb
      assign w_strb[i] = !w_last_vec || (r_tail == 32'd0) || (32'(i) < r_tail);
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = (w_job_total == 32'd0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (w_last_hs) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_base     <= '0;
      r_total    <= '0;
      r_tail     <= '0;
      r_widx     <= '0;
      r_rcnt     <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_stall    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_ok) begin
        r_base     <= base_addr;
        r_total    <= w_job_total;
        r_tail     <= w_job_tail;
        r_widx     <= '0;
        r_rcnt     <= '0;
        r_overflow <= 1'b0;
      end
      if (w_drop) r_overflow <= 1'b1;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_rcnt   <= r_rcnt + 32'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_widx   <= r_widx + 32'd1;
      end
      r_count <= w_count_nxt;
      // Looks at the post-edge occupancy so the stall tracks the FIFO with no extra lag.
      r_stall <= (w_state_nxt == ST_RUN) && (32'(w_free_nxt) <= c_margin);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= data_i;
  end

`ifdef ADD_WB_PERF_CNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (w_start_ok) begin
      r_stall_cycles <= '0;
    end else if (w_req && !mem_ready_i && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles_o = r_stall_cycles;
`else
  assign stall_cycles_o = '0;
`endif

  // Request fields are forced to zero when idle so nothing undriven leaks from the FIFO array.
  assign mem_req_o   = w_req;
  assign mem_addr_o  = w_req ? (r_base + r_widx[ADDR_WIDTH-1:0]) : '0;
  assign mem_wdata_o = w_req ? r_fifo[r_rd_ptr] : '0;
  assign mem_wstrb_o = w_req ? w_strb : '0;
  assign busy_o      = w_busy;
  assign done_o      = (r_state == ST_DONE);
  assign overflow_o  = r_overflow;
  assign stall_o     = r_stall;

endmodule

`default_nettype wire
